// File: rtl/serial_pkg.sv
// Shared definitions for the serial link (transmitter now, receiver later).
package serial_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned min_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Parallel word handshake between a producer (master) and the serial transmitter (slave).
interface serial_tx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              busy;

    modport master (output data, output valid, input ready, input busy);
    modport slave  (input data, input valid, output ready, output busy);

endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: tick marks the last clock of each CLKS_PER_BIT-long bit period.
module bit_timer
    import serial_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int TW = min_width(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] count;

    assign tick = (count == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/serial_tx.sv
// LSB-first framed serial transmitter (start, DATA_W payload bits, stop).
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module serial_tx
    import serial_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    serial_tx_if.slave  tx,
    output logic        sout
);

    localparam int CW = $clog2(DATA_W + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    tx_state_t         state;
    tx_state_t         state_next;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] shreg_next;
    logic [CW-1:0]     bit_cnt;
    logic [CW-1:0]     bit_cnt_next;
    logic              sout_next;
    logic              tick;
`ifdef SERIAL_TX_PARITY_EN
    logic              parity;
    logic              parity_next;
`endif

    assign tx.ready = (state == IDLE);
    assign tx.busy  = ~tx.ready;

    // Timer is held at zero while idle so the start bit gets a full period.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (state == IDLE),
        .tick  (tick)
    );

    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        bit_cnt_next = bit_cnt;
`ifdef SERIAL_TX_PARITY_EN
        parity_next  = parity;
`endif
        case (state)
            IDLE: begin
                if (tx.valid) begin
                    state_next = START;
                    shreg_next = tx.data;
`ifdef SERIAL_TX_PARITY_EN
                    parity_next = ^tx.data;
`endif
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == LAST_BIT) begin
                        bit_cnt_next = '0;
`ifdef SERIAL_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
`ifdef SERIAL_TX_PARITY_EN
            PARITY: begin
                if (tick) begin
                    state_next = STOP;
                end
            end
`endif
            STOP: begin
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The line level is decoded from the next state so sout stays a plain register.
    always_comb begin
        case (state_next)
            START:   sout_next = START_BIT;
            DATA:    sout_next = shreg_next[0];
`ifdef SERIAL_TX_PARITY_EN
            PARITY:  sout_next = parity_next;
`endif
            STOP:    sout_next = STOP_BIT;
            default: sout_next = LINE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            sout    <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            bit_cnt <= bit_cnt_next;
            sout    <= sout_next;
`ifdef SERIAL_TX_PARITY_EN
            parity  <= parity_next;
`endif
        end
    end

endmodule
